ws2812_rx: RTL and testbench



---
 rtl/ws2812_pkg.sv | 34 +++
 rtl/ws2812_bit_decoder.sv | 92 +++++++++
 rtl/ws2812_rx.sv | 148 ++++++++++++++
 tb/tb_ws2812_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions.
//
// Timing constants for a 12 MHz system clock (used by the transmitter, the
// receiver and their benches), receiver geometry, the receiver state enum and
// a small saturating-increment helper for the high-pulse counter.
package ws2812_pkg;

  // 12 MHz bit timing, in clocks.
  localparam int T0H_CLKS     = 4;    // high time of a 0 bit
  localparam int T1H_CLKS     = 8;    // high time of a 1 bit
  localparam int T_BIT_CLKS   = 15;   // full bit period
  localparam int T_RESET_CLKS = 600;  // 50 us latch gap

  // Receiver defaults.
  localparam int T_BIT_THRESH_DEF = 7;
  localparam int T_MIN_HIGH_DEF   = 2;

  // Receiver geometry.
  localparam int SYNC_STAGES = 2;   // input synchronizer depth
  localparam int WORD_BITS   = 24;  // one pixel word
  localparam int HIGH_CNT_W  = 8;   // high-pulse counter width

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,  // waiting for the first bit of a frame
    RX_RECV = 2'd1,  // capturing our own word
    RX_PASS = 2'd2   // forwarding the rest of the frame
  } rx_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [HIGH_CNT_W-1:0] sat_inc_high(input logic [HIGH_CNT_W-1:0] v);
    return (v == {HIGH_CNT_W{1'b1}}) ? v : v + HIGH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_bit_decoder.sv
// WS2812 line decoder.
//
// Synchronizes the asynchronous serial line, measures high and low times and
// turns each falling edge into a decoded bit.
//
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   data_in     : raw serial line (asynchronous)
//   bit_valid   : one-cycle strobe, a non-glitch high pulse just ended
//   bit_value   : decoded value, meaningful while bit_valid is high
//   gap         : one-cycle strobe when the line has been low for T_RESET clocks
//   line_sync   : synchronized line level
module ws2812_bit_decoder
  import ws2812_pkg::*;
#(
  parameter int T_BIT_THRESH = T_BIT_THRESH_DEF,
  parameter int T_MIN_HIGH   = T_MIN_HIGH_DEF,
  parameter int T_RESET      = T_RESET_CLKS
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic bit_valid,
  output logic bit_value,
  output logic gap,
  output logic line_sync
);

  localparam int LOW_W = $clog2(T_RESET + 1);
  localparam logic [LOW_W-1:0]      LOW_SAT  = LOW_W'(T_RESET);
  localparam logic [LOW_W-1:0]      LOW_GAP  = LOW_W'(T_RESET - 1);
  localparam logic [HIGH_CNT_W-1:0] THRESH   = HIGH_CNT_W'(T_BIT_THRESH);
  localparam logic [HIGH_CNT_W-1:0] MIN_HIGH = HIGH_CNT_W'(T_MIN_HIGH);

  // Synchronizer chain: stage 0 samples the pin, each later stage samples
  // the one before it.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = data_in;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  logic                  line;
  logic                  line_prev_reg;
  logic [HIGH_CNT_W-1:0] high_cnt_reg;
  logic [LOW_W-1:0]      low_cnt_reg;
  logic                  rise;
  logic                  fall;

  assign line = sync_reg[SYNC_STAGES-1];
  assign rise = line & ~line_prev_reg;
  assign fall = ~line & line_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg      <= '0;
      line_prev_reg <= 1'b0;
      high_cnt_reg  <= '0;
      low_cnt_reg   <= '0;
    end else begin
      sync_reg      <= sync_next;
      line_prev_reg <= line;
      // The rising-edge cycle is itself the first high clock, so the count
      // restarts at 1; on the falling edge it equals the pulse width.
      if (line) begin
        high_cnt_reg <= rise ? HIGH_CNT_W'(1) : sat_inc_high(high_cnt_reg);
      end
      if (line) begin
        low_cnt_reg <= '0;
      end else if (low_cnt_reg != LOW_SAT) begin
        low_cnt_reg <= low_cnt_reg + LOW_W'(1);
      end
    end
  end

  // The high count is held during the falling-edge cycle, so it can be
  // evaluated directly here.
  assign bit_valid = fall && (high_cnt_reg >= MIN_HIGH);
  assign bit_value = (high_cnt_reg >= THRESH);
  // Fires on the step into saturation, hence once per low period.
  assign gap       = ~line && (low_cnt_reg == LOW_GAP);
  assign line_sync = line;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver / soft pixel.
//
// Behaves like one pixel on a WS2812 chain: captures the first 24-bit word
// of each frame, forwards every later bit, and shows the captured word on
// rgb_data when the latch gap arrives.
//
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   data_in     : serial input line (asynchronous)
//   data_out    : forwarded serial stream, 0 while capturing our own word
//   rgb_data    : displayed word, updated only at latch
//   word        : last captured word, bit 23 = first bit received
//   word_valid  : one-cycle pulse when word updates
//   latch       : one-cycle pulse when a complete frame latches
//   frame_err   : one-cycle pulse when a gap cuts a word short
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int T_BIT_THRESH = T_BIT_THRESH_DEF,
  parameter int T_MIN_HIGH   = T_MIN_HIGH_DEF,
  parameter int T_RESET      = T_RESET_CLKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  output logic                 data_out,
  output logic [WORD_BITS-1:0] rgb_data,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 latch,
  output logic                 frame_err
);

  localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

  logic bit_valid;
  logic bit_value;
  logic gap;
  logic line_sync;

  ws2812_bit_decoder #(
    .T_BIT_THRESH (T_BIT_THRESH),
    .T_MIN_HIGH   (T_MIN_HIGH),
    .T_RESET      (T_RESET)
  ) u_decoder (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .gap       (gap),
    .line_sync (line_sync)
  );

  rx_state_t            state_reg,      state_next;
  logic [WORD_BITS-1:0] shift_reg,      shift_next;
  logic [WORD_BITS-1:0] word_reg,       word_next;
  logic [WORD_BITS-1:0] rgb_reg,        rgb_next;
  logic [4:0]           bit_cnt_reg,    bit_cnt_next;
  logic                 word_valid_reg, word_valid_next;
  logic                 latch_reg,      latch_next;
  logic                 frame_err_reg,  frame_err_next;
  logic                 data_out_reg,   data_out_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RX_IDLE;
      shift_reg      <= '0;
      word_reg       <= '0;
      rgb_reg        <= '0;
      bit_cnt_reg    <= '0;
      word_valid_reg <= 1'b0;
      latch_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      data_out_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      word_reg       <= word_next;
      rgb_reg        <= rgb_next;
      bit_cnt_reg    <= bit_cnt_next;
      word_valid_reg <= word_valid_next;
      latch_reg      <= latch_next;
      frame_err_reg  <= frame_err_next;
      data_out_reg   <= data_out_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    word_next       = word_reg;
    rgb_next        = rgb_reg;
    bit_cnt_next    = bit_cnt_reg;
    word_valid_next = 1'b0;
    latch_next      = 1'b0;
    frame_err_next  = 1'b0;
    // Only the tail of the frame is forwarded; our own word stays local.
    data_out_next   = (state_reg == RX_PASS) && line_sync;

    // A gap needs a sustained low, so it never shares a cycle with a
    // bit strobe; checking gap first is just for readability.
    unique case (state_reg)
      RX_IDLE: begin
        if (bit_valid) begin
          shift_next   = {{(WORD_BITS-1){1'b0}}, bit_value};
          bit_cnt_next = 5'd1;
          state_next   = RX_RECV;
        end
      end
      RX_RECV: begin
        if (gap) begin
          frame_err_next = (bit_cnt_reg != 5'd0);
          bit_cnt_next   = 5'd0;
          state_next     = RX_IDLE;
        end else if (bit_valid) begin
          shift_next = {shift_reg[WORD_BITS-2:0], bit_value};
          if (bit_cnt_reg == LAST_BIT) begin
            word_next       = {shift_reg[WORD_BITS-2:0], bit_value};
            word_valid_next = 1'b1;
            bit_cnt_next    = 5'd0;
            state_next      = RX_PASS;
          end else begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
          end
        end
      end
      RX_PASS: begin
        if (gap) begin
          rgb_next   = word_reg;
          latch_next = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  assign data_out   = data_out_reg;
  assign rgb_data   = rgb_reg;
  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign latch      = latch_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives WS2812 frames (the bench acts as the
// transmitter) and checks captured words, latches, frame errors and the
// forwarded stream against what a pixel should do with each frame.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int T_RESET = T_RESET_CLKS;
  localparam int GAP_CLKS = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in;
  logic        data_out;
  logic [23:0] rgb_data;
  logic [23:0] word;
  logic        word_valid;
  logic        latch;
  logic        frame_err;

  always #5 clk = ~clk;

  ws2812_rx dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .rgb_data   (rgb_data),
    .word       (word),
    .word_valid (word_valid),
    .latch      (latch),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on falling clock edge) ----------------
  int          cyc = 0;
  int          last_fall = 0;
  bit          fwd_expect = 1'b0;
  bit          in_fwd = 1'b0;
  logic        din_prev = 1'b0;
  logic        dout_prev = 1'b0;
  int          in_rise = 0;
  int          out_rise = 0;
  logic [23:0] wv_q[$];
  int          wv_dly_q[$];
  logic [23:0] lat_q[$];
  int          lat_dly_q[$];
  int          ferr_n = 0;
  int          in_rise_q[$];
  int          in_w_q[$];
  int          out_rise_q[$];
  int          out_w_q[$];

  always @(negedge clk) begin
    cyc++;
    if (word_valid === 1'b1) begin
      wv_q.push_back(word);
      wv_dly_q.push_back(cyc - last_fall);
    end
    if (latch === 1'b1) begin
      lat_q.push_back(rgb_data);
      lat_dly_q.push_back(cyc - last_fall);
    end
    if (frame_err === 1'b1) ferr_n++;
    if (data_in && !din_prev) begin
      in_rise = cyc;
      in_fwd  = fwd_expect;
    end
    if (!data_in && din_prev) begin
      last_fall = cyc;
      if (in_fwd) begin
        in_rise_q.push_back(in_rise);
        in_w_q.push_back(cyc - in_rise);
      end
    end
    if (data_out === 1'b1 && !dout_prev) out_rise = cyc;
    if (data_out !== 1'b1 && dout_prev) begin
      out_rise_q.push_back(out_rise);
      out_w_q.push_back(cyc - out_rise);
    end
    din_prev  = data_in;
    dout_prev = (data_out === 1'b1);
  end

  task automatic clear_mon();
    wv_q.delete();  wv_dly_q.delete();
    lat_q.delete(); lat_dly_q.delete();
    in_rise_q.delete(); in_w_q.delete();
    out_rise_q.delete(); out_w_q.delete();
    ferr_n = 0;
  endtask

  // ---------------- stimulus ----------------
  // Called #1 after a rising edge; holds the level for n sampled clocks.
  task automatic drive(input logic level, input int n);
    data_in = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [47:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      int   hi;
      int   lo;
      b  = bits[47-i];
      hi = b ? T1H_CLKS : T0H_CLKS;
      lo = T_BIT_CLKS - hi;
      fwd_expect = (i >= WORD_BITS);
      drive(1'b1, hi);
      if (glitch && i < WORD_BITS - 1 && i < nbits - 1) begin
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, lo - 4);
      end else begin
        drive(1'b0, lo);
      end
    end
    fwd_expect = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // A pixel keeps the first 24 bits, forwards the rest, latches on the gap
  // if the word was complete, and flags an error if it was not.
  logic [23:0] exp_rgb  = '0;
  logic [23:0] exp_word = '0;
  int          frame_no = 0;

  task automatic verify_frame(input logic [47:0] bits, input int nbits);
    int n_fwd;
    int n_cmp;
    n_fwd = (nbits > WORD_BITS) ? nbits - WORD_BITS : 0;
    if (nbits >= WORD_BITS) begin
      exp_word = bits[47:24];
      check_eq("wv_count", wv_q.size(), 1);
      if (wv_q.size() > 0) begin
        check_eq("word", wv_q[0], exp_word);
        check_eq("wv_latency", wv_dly_q[0], 3);
      end
      check_eq("latch_count", lat_q.size(), 1);
      if (lat_q.size() > 0) begin
        check_eq("latch_rgb", lat_q[0], exp_word);
        check_eq("latch_latency", lat_dly_q[0], T_RESET + 2);
      end
      exp_rgb = exp_word;
      check_eq("frame_err_count", ferr_n, 0);
    end else begin
      check_eq("wv_count", wv_q.size(), 0);
      check_eq("latch_count", lat_q.size(), 0);
      check_eq("frame_err_count", ferr_n, (nbits > 0) ? 1 : 0);
    end
    check_eq("rgb_data", rgb_data, exp_rgb);
    check_eq("word_out", word, exp_word);
    check_eq("fwd_count", out_rise_q.size(), n_fwd);
    check_eq("fwd_in_count", in_rise_q.size(), n_fwd);
    n_cmp = (out_rise_q.size() < in_rise_q.size()) ? out_rise_q.size() : in_rise_q.size();
    for (int k = 0; k < n_cmp; k++) begin
      int dw;
      check_eq("fwd_delay", out_rise_q[k] - in_rise_q[k], 3);
      dw = out_w_q[k] - in_w_q[k];
      check_eq("fwd_width_pm1", (dw >= -1 && dw <= 1) ? 1 : 0, 1);
    end
    $display("frame %0d bits=%0d word=%h rgb=%h fwd=%0d ferr=%0d",
             frame_no, nbits, word, rgb_data, out_rise_q.size(), ferr_n);
    frame_no++;
    clear_mon();
  endtask

  task automatic run_frame(input logic [47:0] bits, input int nbits, input bit glitch);
    clear_mon();
    send_bits(bits, nbits, glitch);
    drive(1'b0, GAP_CLKS);
    verify_frame(bits, nbits);
  endtask

  task automatic check_all_zero(input string ctx);
    check_eq({ctx, "_rgb"},   rgb_data,   24'h0);
    check_eq({ctx, "_word"},  word,       24'h0);
    check_eq({ctx, "_wv"},    word_valid, 1'b0);
    check_eq({ctx, "_latch"}, latch,      1'b0);
    check_eq({ctx, "_ferr"},  frame_err,  1'b0);
    check_eq({ctx, "_dout"},  data_out,   1'b0);
  endtask

  initial begin
    logic [23:0] loop_words [4];
    loop_words[0] = 24'h100000;
    loop_words[1] = 24'h001000;
    loop_words[2] = 24'h000010;
    loop_words[3] = 24'h101010;

    data_in = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 20);

    // Directed frames.
    run_frame({24'h100010, 24'h000000}, 24, 1'b0);
    run_frame({24'hAA55F0, 24'h0F0F0F}, 48, 1'b0);
    run_frame({24'h123456, 24'h000000}, 24, 1'b1);
    run_frame({24'hB3C5A5, 24'h000000}, 10, 1'b0);
    run_frame({24'h000001, 24'h000000}, 24, 1'b0);

    // Reset in the middle of a frame.
    clear_mon();
    send_bits({24'h5A5A5A, 24'h0}, 12, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_rgb  = '0;
    exp_word = '0;
    drive(1'b0, 20);
    clear_mon();
    run_frame({24'hFFFFFF, 24'h000000}, 24, 1'b0);

    // Randomized frames: random length (partial to two words), data, glitches.
    for (int r = 0; r < 10; r++) begin
      logic [47:0] bits;
      int          nbits;
      bit          gl;
      bits  = {$urandom(), $urandom()};
      nbits = $urandom_range(1, 48);
      gl    = ($urandom_range(0, 1) == 1);
      run_frame(bits, nbits, gl);
    end

    // Transmitter-style loopback of a fixed word cycle.
    for (int r = 0; r < 4; r++) begin
      run_frame({loop_words[r], 24'h000000}, 24, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
